// File: rtl/mc_control_fsm_pkg.sv
// Shared constants for the multi-cycle sequencer: RV32I opcodes, state encodings
// and the datapath select values used by the PC mux, register write mux and ALU control.
package mc_control_fsm_pkg;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_ALU    = 2'd1;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd2;

  localparam logic [1:0] REG_SRC_ALUOUT = 2'd0;
  localparam logic [1:0] REG_SRC_MDR    = 2'd1;
  localparam logic [1:0] REG_SRC_PC4    = 2'd2;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd2;

  // Opcodes that need an EX cycle; anything else is ECALL or illegal and retires in ID.
  function automatic logic needs_ex(input logic [6:0] op);
    return (op == OP_ARITH) || (op == OP_ARITH_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control sequencer: one state register, one next-state block
// and one combinational output block driving the datapath enables and selects.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] part_of_inst,
  input  logic                bcond,
  input  logic                halt_req,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_source,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          reg_src,
  output logic                alu_src_a,
  output logic                alu_src_b,
  output logic [1:0]          alu_op,
  output logic                is_halted,
  output logic [2:0]          state
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [6:0] opcode;

  assign opcode = part_of_inst[6:0];
  assign state  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (needs_ex(opcode))                      state_d = S_EX;
        else if ((opcode == OP_ECALL) && halt_req) state_d = S_HALT;
        else                                       state_d = S_IF;
      end
      S_EX: begin
        if ((opcode == OP_ARITH) || (opcode == OP_ARITH_IMM))   state_d = S_WB;
        else if ((opcode == OP_LOAD) || (opcode == OP_STORE))   state_d = S_MEM;
        else                                                    state_d = S_IF;
      end
      S_MEM: begin
        if (mem_ready) state_d = (opcode == OP_LOAD) ? S_WB : S_IF;
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    pc_source = PC_SRC_PC4;
    ir_write  = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_src   = REG_SRC_ALUOUT;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_OP_ADD;
    is_halted = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
      end
      // ALUOut captures PC+imm here so branch/JAL targets are ready in EX.
      S_ID: begin
        alu_src_b = 1'b1;
        if (!needs_ex(opcode) && !((opcode == OP_ECALL) && halt_req)) begin
          pc_write = 1'b1;
        end
      end
      S_EX: begin
        case (opcode)
          OP_ARITH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_FUNCT;
          end
          OP_ARITH_IMM: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            alu_op    = ALU_OP_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_BRANCH;
            pc_write  = 1'b1;
            pc_source = bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
          end
          // rd gets the old PC+4: PC and register file update on the same edge.
          OP_JAL: begin
            pc_write  = 1'b1;
            pc_source = PC_SRC_ALUOUT;
            reg_write = 1'b1;
            reg_src   = REG_SRC_PC4;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_source = PC_SRC_ALU;
            reg_write = 1'b1;
            reg_src   = REG_SRC_PC4;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
        pc_write  = (opcode == OP_STORE) && mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_src   = (opcode == OP_LOAD) ? REG_SRC_MDR : REG_SRC_ALUOUT;
        pc_write  = 1'b1;
      end
      S_HALT: is_halted = 1'b1;
      default: ;
    endcase

    // The state register already reads IF during reset; keep IF from issuing a fetch.
    if (reset) begin
      pc_write  = 1'b0;
      pc_source = PC_SRC_PC4;
      ir_write  = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      reg_src   = REG_SRC_ALUOUT;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = ALU_OP_ADD;
      is_halted = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-instruction state/control sequences
// with hand-derived expected control words.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] part_of_inst;
  logic       bcond, halt_req, mem_ready;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic       alu_src_a, alu_src_b, is_halted;
  logic [1:0] pc_source, reg_src, alu_op;
  logic [2:0] state;
  logic [14:0] ctl;

  int tests_run = 0;
  int tests_failed = 0;

  // Control word layout: pcw|pcs(2)|irw|iod|mr|mw|rw|rs(2)|asa|asb|aop(2)|halted
  localparam logic [14:0] C_ZERO     = 15'b0_00_0_0_0_0_0_00_0_0_00_0;
  localparam logic [14:0] C_IF_WAIT  = 15'b0_00_0_0_1_0_0_00_0_0_00_0;
  localparam logic [14:0] C_IF_GO    = 15'b0_00_1_0_1_0_0_00_0_0_00_0;
  localparam logic [14:0] C_ID       = 15'b0_00_0_0_0_0_0_00_0_1_00_0;
  localparam logic [14:0] C_ID_SKIP  = 15'b1_00_0_0_0_0_0_00_0_1_00_0;
  localparam logic [14:0] C_EX_R     = 15'b0_00_0_0_0_0_0_00_1_0_01_0;
  localparam logic [14:0] C_EX_I     = 15'b0_00_0_0_0_0_0_00_1_1_01_0;
  localparam logic [14:0] C_EX_MEM   = 15'b0_00_0_0_0_0_0_00_1_1_00_0;
  localparam logic [14:0] C_EX_BT    = 15'b1_10_0_0_0_0_0_00_1_0_10_0;
  localparam logic [14:0] C_EX_BN    = 15'b1_00_0_0_0_0_0_00_1_0_10_0;
  localparam logic [14:0] C_EX_JAL   = 15'b1_10_0_0_0_0_1_10_0_0_00_0;
  localparam logic [14:0] C_EX_JALR  = 15'b1_01_0_0_0_0_1_10_1_1_00_0;
  localparam logic [14:0] C_MEM_LD   = 15'b0_00_0_1_1_0_0_00_0_0_00_0;
  localparam logic [14:0] C_MEM_ST   = 15'b0_00_0_1_0_1_0_00_0_0_00_0;
  localparam logic [14:0] C_MEM_STGO = 15'b1_00_0_1_0_1_0_00_0_0_00_0;
  localparam logic [14:0] C_WB_R     = 15'b1_00_0_0_0_0_1_00_0_0_00_0;
  localparam logic [14:0] C_WB_LD    = 15'b1_00_0_0_0_0_1_01_0_0_00_0;
  localparam logic [14:0] C_HALT     = 15'b0_00_0_0_0_0_0_00_0_0_00_1;

  assign ctl = {pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write,
                reg_write, reg_src, alu_src_a, alu_src_b, alu_op, is_halted};

  always #5 clk = ~clk;

  mc_control_fsm #(.OPCODE_W(7)) dut (
    .clk(clk), .reset(reset), .part_of_inst(part_of_inst), .bcond(bcond),
    .halt_req(halt_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_source(pc_source), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_src(reg_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .is_halted(is_halted), .state(state)
  );

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; part_of_inst = 7'b0110011;
    bcond = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (state !== 3'd0 || ctl !== C_ZERO) begin
      tests_failed++;
      $display("FAIL reset_hold: state=%0d ctl=%h, expected state=0 ctl=%h", state, ctl, C_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset: released");
  endtask

  task automatic test_arith(input logic [6:0] op, input logic [14:0] ex_ctl, input string nm);
    logic [2:0]  es [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [14:0] ec [5];
    ec = '{C_IF_GO, C_ID, ex_ctl, C_WB_R, C_IF_GO};
    part_of_inst = op; mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if (state !== es[c] || ctl !== ec[c]) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 nm, c, state, ctl, es[c], ec[c]);
      end
      if (c < 4) @(negedge clk);
    end
    $display("[TB] %s: 4-cycle sequence checked", nm);
  endtask

  task automatic test_load_wait();
    logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  es [8]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic [14:0] ec [8]  = '{C_IF_GO, C_ID, C_EX_MEM, C_MEM_LD, C_MEM_LD, C_MEM_LD,
                             C_WB_LD, C_IF_GO};
    part_of_inst = 7'b0000011;
    for (int c = 0; c < 8; c++) begin
      mem_ready = rdy[c];
      #1;
      tests_run++;
      if (state !== es[c] || ctl !== ec[c]) begin
        tests_failed++;
        $display("FAIL load_wait cycle %0d: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 c, state, ctl, es[c], ec[c]);
      end
      if (c < 7) @(negedge clk);
    end
    $display("[TB] load_wait: 7-cycle load with 2 wait states checked");
  endtask

  task automatic test_store();
    logic        rdy [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  es [6]  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [14:0] ec [6]  = '{C_IF_WAIT, C_IF_GO, C_ID, C_EX_MEM, C_MEM_STGO, C_IF_GO};
    part_of_inst = 7'b0100011;
    for (int c = 0; c < 6; c++) begin
      mem_ready = rdy[c];
      #1;
      tests_run++;
      if (state !== es[c] || ctl !== ec[c]) begin
        tests_failed++;
        $display("FAIL store cycle %0d: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 c, state, ctl, es[c], ec[c]);
      end
      if (c < 5) @(negedge clk);
    end
    $display("[TB] store: fetch wait + zero-wait store checked");
  endtask

  // Three-cycle instructions: IF, ID, EX, then back to IF.
  task automatic test_short(input logic [6:0] op, input logic bc, input logic [14:0] ex_ctl,
                            input string nm);
    logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    logic [14:0] ec [4];
    ec = '{C_IF_GO, C_ID, ex_ctl, C_IF_GO};
    part_of_inst = op; bcond = bc; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++;
      if (state !== es[c] || ctl !== ec[c]) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 nm, c, state, ctl, es[c], ec[c]);
      end
      if (c < 3) @(negedge clk);
    end
    bcond = 1'b0;
    $display("[TB] %s: 3-cycle sequence checked", nm);
  endtask

  // ECALL without halt and illegal opcodes retire in ID.
  task automatic test_id_retire(input logic [6:0] op, input string nm);
    logic [2:0]  es [3] = '{3'd0, 3'd1, 3'd0};
    logic [14:0] ec [3] = '{C_IF_GO, C_ID_SKIP, C_IF_GO};
    part_of_inst = op; halt_req = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (state !== es[c] || ctl !== ec[c]) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 nm, c, state, ctl, es[c], ec[c]);
      end
      if (c < 2) @(negedge clk);
    end
    $display("[TB] %s: 2-cycle retire checked", nm);
  endtask

  task automatic test_halt();
    part_of_inst = 7'b1110011; halt_req = 1'b1; mem_ready = 1'b1;
    #1;
    tests_run++;
    if (state !== 3'd0 || ctl !== C_IF_GO) begin
      tests_failed++;
      $display("FAIL halt_if: state=%0d ctl=%h, expected state=0 ctl=%h", state, ctl, C_IF_GO);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (state !== 3'd1 || ctl !== C_ID) begin
      tests_failed++;
      $display("FAIL halt_id: state=%0d ctl=%h, expected state=1 ctl=%h", state, ctl, C_ID);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_ready = c[0];
      halt_req  = ~c[1];
      part_of_inst = (c < 10) ? 7'b0110011 : 7'b1110011;
      #1;
      tests_run++;
      if (state !== 3'd5 || ctl !== C_HALT) begin
        tests_failed++;
        $display("FAIL halt_hold cycle %0d: state=%0d ctl=%h, expected state=5 ctl=%h",
                 c, state, ctl, C_HALT);
      end
    end
    $display("[TB] halt: ECALL halt held for 20 cycles");
  endtask

  task automatic test_reset_in_mem();
    reset = 1'b1; halt_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; part_of_inst = 7'b0100011;
    for (int c = 0; c < 3; c++) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    tests_run++;
    if (state !== 3'd3 || ctl !== C_MEM_ST) begin
      tests_failed++;
      $display("FAIL rst_mem_pre: state=%0d ctl=%h, expected state=3 ctl=%h", state, ctl, C_MEM_ST);
    end
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (mem_write !== 1'b0 || state !== 3'd0 || ctl !== C_ZERO) begin
      tests_failed++;
      $display("FAIL rst_mem_abort: state=%0d ctl=%h, expected state=0 ctl=%h", state, ctl, C_ZERO);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    tests_run++;
    if (state !== 3'd0 || ctl !== C_IF_WAIT) begin
      tests_failed++;
      $display("FAIL rst_mem_if_wait: state=%0d ctl=%h, expected state=0 ctl=%h", state, ctl, C_IF_WAIT);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (state !== 3'd0 || ctl !== C_IF_WAIT) begin
      tests_failed++;
      $display("FAIL rst_mem_if_wait2: state=%0d ctl=%h, expected state=0 ctl=%h", state, ctl, C_IF_WAIT);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if (state !== 3'd0 || ctl !== C_IF_GO) begin
      tests_failed++;
      $display("FAIL rst_mem_if_go: state=%0d ctl=%h, expected state=0 ctl=%h", state, ctl, C_IF_GO);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (state !== 3'd1) begin
      tests_failed++;
      $display("FAIL rst_mem_id: state=%0d, expected state=1", state);
    end
    $display("[TB] reset_in_mem: store aborted, refetch waits for mem_ready");
  endtask

  initial begin
    test_reset();
    test_arith(7'b0110011, C_EX_R, "add");
    test_arith(7'b0010011, C_EX_I, "addi");
    test_load_wait();
    test_store();
    test_short(7'b1100011, 1'b1, C_EX_BT, "branch_taken");
    test_short(7'b1100011, 1'b0, C_EX_BN, "branch_not_taken");
    test_short(7'b1101111, 1'b0, C_EX_JAL, "jal");
    test_short(7'b1100111, 1'b1, C_EX_JALR, "jalr");
    test_id_retire(7'b1110011, "ecall_continue");
    test_id_retire(7'b1111111, "illegal_opcode");
    test_halt();
    test_reset_in_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle sequencer for the RV32I multi-cycle core. It consumes the 7-bit opcode latched in the instruction register plus datapath status (`bcond`, `mem_ready`, `halt_req`). Each state drives the datapath enables and mux selects: PC, IR, register file, memory, ALU source and ALU op. It sits between the instruction register and the datapath control inputs, downstream of fetch and alongside the combinational opcode decoder.

## Interface
Parameters:
- `OPCODE_W`, 7: opcode width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `part_of_inst`  in  7  opcode field from the IR output.
- `bcond`  in  1  branch-condition result from the ALU; valid in EX for BRANCH.
- `halt_req`  in  1  datapath asserts when x17 == 10; sampled in ID for ECALL.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `pc_write`  out  1  PC register load enable.
- `pc_source`  out  2  PC input select: 0 = PC+4 adder, 1 = ALU result, 2 = ALUOut register.
- `ir_write`  out  1  IR load enable.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register file write enable.
- `reg_src`  out  2  register write data select: 0 = ALUOut, 1 = MDR, 2 = PC+4.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alu_src_b`  out  1  ALU B select: 0 = register B, 1 = immediate.
- `alu_op`  out  2  ALU op class: 0 = ADD, 1 = FUNCT, 2 = BRANCH compare.
- `is_halted`  out  1  sticky halt flag.
- `state`  out  3  current state, for debug and bench.

## Operation
- States: IF, ID, EX, MEM, WB, HALT. Any output not listed for a state is 0.
- **IF**
  - Drives `mem_read=1`, `i_or_d=0`.
  - Stays in IF while `mem_ready=0`.
  - On `mem_ready=1`: asserts `ir_write=1` and goes to ID.
- **ID**
  - Drives `alu_src_a=0`, `alu_src_b=1`, `alu_op=ADD`; ALUOut latches PC+imm as the branch/JAL target.
  - ECALL with `halt_req=1`: go to HALT.
  - ECALL with `halt_req=0`, or any unknown opcode: `pc_write=1`, `pc_source=0`, go to IF.
  - All other opcodes: go to EX.
- **EX**
  - ARITHMETIC: `alu_src_a=1`, `alu_src_b=0`, `alu_op=FUNCT`; go to WB.
  - ARITHMETIC_IMM: as ARITHMETIC but `alu_src_b=1`; go to WB.
  - LOAD / STORE: `alu_src_a=1`, `alu_src_b=1`, `alu_op=ADD`; go to MEM.
  - BRANCH: `alu_src_a=1`, `alu_src_b=0`, `alu_op=BRANCH`, `pc_write=1`, `pc_source = bcond ? 2 : 0`; go to IF.
  - JAL: `pc_write=1`, `pc_source=2`, `reg_write=1`, `reg_src=2`; go to IF. rd receives the old PC+4 because the PC and the register file update on the same edge.
  - JALR: `alu_src_a=1`, `alu_src_b=1`, `alu_op=ADD`, `pc_write=1`, `pc_source=1`, `reg_write=1`, `reg_src=2`; go to IF. The datapath clears bit 0 of the target.
- **MEM**
  - Drives `i_or_d=1`; `mem_read=1` for LOAD, `mem_write=1` for STORE.
  - Stays in MEM while `mem_ready=0`.
  - On `mem_ready=1`: LOAD goes to WB (MDR latches); STORE asserts `pc_write=1`, `pc_source=0` and goes to IF.
- **WB**
  - Drives `reg_write=1`, `reg_src` = 1 for LOAD, 0 otherwise; `pc_write=1`, `pc_source=0`; go to IF.
- **HALT**
  - All enables are 0 and `is_halted=1`.
  - Absorbing; only reset exits.

## Timing
- Reset:
  - `state` = IF asynchronously.
  - While `reset` is high, `pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write` and `is_halted` are forced to 0; all other outputs are 0.
- Outputs are combinational from `state`, `part_of_inst`, `bcond`, `halt_req` and `mem_ready` (Mealy where gated by `mem_ready` or `bcond`).
- `state` is registered.
- Memory handshake:
  - `mem_read`/`mem_write` and `i_or_d` stay constant until the cycle in which `mem_ready=1`; that cycle completes the request.
  - `mem_ready` is ignored outside IF and MEM.
  - A `mem_ready` already high on entry completes in the first cycle.
- Latency with zero-wait memory: ARITHMETIC/IMM 4 cycles, LOAD 5, STORE 4, BRANCH 3, JAL/JALR 3, ECALL-continue 2.
- Each memory wait cycle adds exactly 1 cycle.
- `part_of_inst` is only trusted from ID onward; it is ignored in IF.
- Reset asserted mid-instruction aborts it with no further enables; the sequencer restarts at IF.

## Structure
- Opcode constants stay in the shared `opcodes.v`.
- A new shared header `mc_ctrl_defs.v` holds:
  - state encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5;
  - `pc_source`, `reg_src` and `alu_op` select constants, so the datapath muxes and the ALU control use the same values.
- No sub-module: one state register, one next-state block, one output block.

## Test plan
- ADD (0110011), `mem_ready` tied 1:
  - `state` sequence IF, ID, EX, WB, IF;
  - `reg_write=1` and `reg_src=0` only in WB;
  - `pc_write` pulses once with `pc_source=0`.
- LOAD with `mem_ready` low for 2 MEM cycles:
  - `mem_read=1` and `i_or_d=1` are held for 3 MEM cycles;
  - WB follows with `reg_src=1`;
  - total 7 cycles.
- BRANCH:
  - with `bcond=1`, EX shows `pc_write=1`, `pc_source=2`;
  - with `bcond=0`, `pc_source=0`;
  - both return to IF after 3 cycles.
- JAL and JALR:
  - EX asserts `reg_write=1` and `reg_src=2`;
  - `pc_source` is 2 for JAL and 1 for JALR;
  - there is no WB cycle.
- ECALL:
  - with `halt_req=1`: HALT and `is_halted=1` persist for 20 cycles with all enables 0;
  - with `halt_req=0`: back to IF after 2 cycles.
- Reset asserted in MEM with `mem_write=1`:
  - `mem_write` drops the same cycle;
  - after release, `state` = IF and the first `ir_write` occurs only on `mem_ready`.
